asic_link_ctrl: RTL and testbench
=================================

Name: asic_link_ctrl

Overview:
- Sequences the 128-bit bidirectional FPGA-ASIC data link. It handles the ASIC config request, bus direction switching, flow control and chip select.
- Write words (config/activations) go from an upstream stream to the pad bus. Read words from the pad bus go to a downstream stream.
- The block guarantees the FPGA output driver and read sampling never overlap. A fixed turnaround gap separates every direction change.
- Sits in the FPGA top between the local buffers and the IO_spi_data tristate pads.

Parameters:
- DATA_W, 128, bus/word width.
- SYNC_STAGES, 2, flop depth of the synchronizers on ASIC-sourced inputs.
- TURN_CYC, 4, idle cycles on every bus direction change (range 1..255).
- TIMEOUT, 65535, stall cycles before the error state (16-bit counter).

Ports:
- I_clk_src_p  in  1  link clock.
- I_rst  in  1  synchronous reset, active-high.
- I_start  in  1  one-cycle pulse that arms a session.
- I_config_req  in  1  ASIC requests a session (async; synchronized internally).
- I_switch_rdwr  in  1  ASIC direction: 0 = FPGA writes, 1 = FPGA reads (async; synchronized).
- I_near_full  in  1  ASIC input buffer near full (async; synchronized).
- I_wr_data  in  DATA_W  upstream write word.
- I_wr_vld  in  1  upstream word valid.
- O_wr_rdy  out  1  word accepted this cycle.
- O_pad_data  out  DATA_W  data to the pad output driver.
- O_bus_oe  out  1  pad tristate enable (1 = FPGA drives).
- I_pad_data  in  DATA_W  data from the pad input buffer.
- O_rd_data  out  DATA_W  captured read word.
- O_rd_vld  out  1  read word valid (one-cycle strobe).
- O_OE_req  out  1  tells the ASIC that the FPGA is driving the bus.
- O_spi_cs_n  out  1  chip select, active-low.
- O_sck_en  out  1  gate enable for the transfer clock.
- O_busy  out  1  high whenever the state is not IDLE.
- O_err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset values:
  - O_spi_cs_n=1.
  - O_bus_oe, O_OE_req, O_sck_en, O_wr_rdy, O_rd_vld, O_busy = 0.
  - O_err_timeout=0.
  - Data registers = 0.
  - State = IDLE.
- Reset mid-operation returns every output to its reset value at the next edge. Synchronizer flops also clear.
- *_s denotes a synchronized input, valid SYNC_STAGES cycles after the pin changes.
- FSM transitions:
  - IDLE: I_start -> WAIT_REQ; O_err_timeout clears on I_start.
  - WAIT_REQ: config_req_s=1 and switch_rdwr_s=0 -> WR_SETUP. config_req_s=1 and switch_rdwr_s=1 -> TURN (target READ). Timeout -> ERR.
  - WR_SETUP: O_spi_cs_n=0, O_OE_req=1, O_bus_oe=1, no sck. Hold TURN_CYC cycles, then -> WRITE.
  - WRITE: transfer when I_wr_vld && !near_full_s. In a transfer cycle, O_wr_rdy=1 and O_sck_en=1, and O_pad_data registers I_wr_data (1-cycle latency). Otherwise O_sck_en=0 and O_pad_data holds. switch_rdwr_s=1 -> TURN (target READ). config_req_s=0 -> DONE. If both occur in the same cycle, DONE wins.
  - TURN: O_bus_oe=0, O_OE_req=0, O_sck_en=0, cs_n stays low. Count TURN_CYC cycles, then go to the target state.
  - READ: O_sck_en=1 every cycle. I_pad_data is registered to O_rd_data with O_rd_vld=1 the next cycle. switch_rdwr_s=0 with config_req_s=1 -> WR_SETUP. config_req_s=0 -> DONE (DONE wins).
  - DONE: one cycle with cs_n=1 and all enables 0, then -> IDLE.
  - ERR: same outputs as DONE plus O_err_timeout=1. Stays in ERR until I_start, which moves to WAIT_REQ.
- Timeout counter:
  - Increments in WAIT_REQ, and in WRITE cycles with no transfer.
  - Clears on any transfer or state change.
  - Reaching TIMEOUT -> ERR.
- Invariants:
  - O_bus_oe=1 only in WR_SETUP and WRITE.
  - O_rd_vld never asserts while O_bus_oe=1, or within TURN_CYC cycles after O_bus_oe falls.
  - O_wr_rdy only in WRITE.
- I_start outside IDLE/ERR is ignored.
- near_full_s rising mid-burst: the word presented that cycle is not accepted (O_wr_rdy=0), and no word is lost or duplicated.

Test Plan:
- Reset, then I_start with config_req=1, switch_rdwr=0 and 8 back-to-back valid words 0x1..0x8 -> cs_n falls; 4 cycles later O_wr_rdy pulses 8 times; O_pad_data sequence is 1..8; O_bus_oe=1 throughout.
- During the write burst, assert near_full for 5 cycles after word 3 -> O_wr_rdy=0 and O_sck_en=0 for those cycles (plus sync delay); words 4..8 then follow in order with no gaps or duplicates.
- Raise switch_rdwr mid-write -> O_bus_oe falls, 4 idle cycles, then READ; I_pad_data 0xA5..A5 gives O_rd_vld with that value 1 cycle later; no rd_vld while oe is high.
- Drop config_req in READ -> DONE: cs_n=1 for 1 cycle, O_busy=0 next cycle; toggle switch_rdwr and config_req in the same cycle -> DONE wins.
- I_start with config_req held 0 and TIMEOUT=100 -> ERR after 100 cycles; O_err_timeout=1 until the next I_start.
- Assert I_rst in WRITE -> all outputs at reset values at the next edge; a new session completes normally.

Source files
------------

// File: rtl/asic_link_ctrl.sv
// asic_link_ctrl: sequences the 128-bit bidirectional FPGA-ASIC link -- session
// handshake, bus direction turnaround, write flow control and chip select.
module asic_link_ctrl #(
  parameter int DATA_W      = 128,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYC    = 4,
  parameter int TIMEOUT     = 65535
) (
  input  logic              I_clk_src_p,
  input  logic              I_rst,
  input  logic              I_start,
  input  logic              I_config_req,
  input  logic              I_switch_rdwr,
  input  logic              I_near_full,
  input  logic [DATA_W-1:0] I_wr_data,
  input  logic              I_wr_vld,
  output logic              O_wr_rdy,
  output logic [DATA_W-1:0] O_pad_data,
  output logic              O_bus_oe,
  input  logic [DATA_W-1:0] I_pad_data,
  output logic [DATA_W-1:0] O_rd_data,
  output logic              O_rd_vld,
  output logic              O_OE_req,
  output logic              O_spi_cs_n,
  output logic              O_sck_en,
  output logic              O_busy,
  output logic              O_err_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_REQ = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WRITE    = 3'd3,
    ST_TURN     = 3'd4,
    ST_READ     = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } state_e;

  state_e state_r;
  state_e state_nxt_s;

  logic [SYNC_STAGES-1:0] cfg_sync_r;
  logic [SYNC_STAGES-1:0] dir_sync_r;
  logic [SYNC_STAGES-1:0] nf_sync_r;
  logic                   config_req_s;
  logic                   switch_rdwr_s;
  logic                   near_full_s;

  logic [7:0]        turn_cnt_r;
  logic [15:0]       tmo_cnt_r;
  logic [DATA_W-1:0] pad_data_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_vld_r;
  logic              bus_oe_r;
  logic              cs_n_r;
  logic              busy_r;
  logic              err_r;

  logic start_ok_s;
  logic turn_done_s;
  logic tmo_hit_s;
  logic xfer_s;
  logic stall_s;
  logic rd_cap_s;
  logic oe_nxt_s;
  logic cs_n_nxt_s;
  logic busy_nxt_s;

  // Synchronizer chains for the ASIC-driven control pins
  always_ff @(posedge I_clk_src_p) begin
    if (I_rst) begin
      cfg_sync_r <= {SYNC_STAGES{1'b0}};
      dir_sync_r <= {SYNC_STAGES{1'b0}};
      nf_sync_r  <= {SYNC_STAGES{1'b0}};
    end else begin
      cfg_sync_r <= {cfg_sync_r[SYNC_STAGES-2:0], I_config_req};
      dir_sync_r <= {dir_sync_r[SYNC_STAGES-2:0], I_switch_rdwr};
      nf_sync_r  <= {nf_sync_r[SYNC_STAGES-2:0], I_near_full};
    end
  end

  assign config_req_s  = cfg_sync_r[SYNC_STAGES-1];
  assign switch_rdwr_s = dir_sync_r[SYNC_STAGES-1];
  assign near_full_s   = nf_sync_r[SYNC_STAGES-1];

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    start_ok_s  = I_start && ((state_r == ST_IDLE) || (state_r == ST_ERR));
    turn_done_s = (turn_cnt_r == 8'(TURN_CYC - 1));
    tmo_hit_s   = (tmo_cnt_r == 16'(TIMEOUT - 1));
    // A word is only taken while the session stays in WRITE, so a word is
    // never accepted in the cycle the bus is about to be released.
    xfer_s      = (state_r == ST_WRITE) && I_wr_vld && !near_full_s &&
                  config_req_s && !switch_rdwr_s;
    stall_s     = (state_r == ST_WAIT_REQ) || ((state_r == ST_WRITE) && !xfer_s);

    case (state_r)
      ST_IDLE: begin
        if (I_start) state_nxt_s = ST_WAIT_REQ;
        else         state_nxt_s = ST_IDLE;
      end
      ST_WAIT_REQ: begin
        if (config_req_s && !switch_rdwr_s) state_nxt_s = ST_WR_SETUP;
        else if (config_req_s)              state_nxt_s = ST_TURN;
        else if (tmo_hit_s)                 state_nxt_s = ST_ERR;
        else                                state_nxt_s = ST_WAIT_REQ;
      end
      ST_WR_SETUP: begin
        if (turn_done_s) state_nxt_s = ST_WRITE;
        else             state_nxt_s = ST_WR_SETUP;
      end
      ST_WRITE: begin
        if (!config_req_s)               state_nxt_s = ST_DONE;
        else if (switch_rdwr_s)          state_nxt_s = ST_TURN;
        else if (tmo_hit_s && !xfer_s)   state_nxt_s = ST_ERR;
        else                             state_nxt_s = ST_WRITE;
      end
      ST_TURN: begin
        if (turn_done_s) state_nxt_s = ST_READ;
        else             state_nxt_s = ST_TURN;
      end
      ST_READ: begin
        if (!config_req_s)       state_nxt_s = ST_DONE;
        else if (!switch_rdwr_s) state_nxt_s = ST_WR_SETUP;
        else                     state_nxt_s = ST_READ;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_ERR: begin
        if (I_start) state_nxt_s = ST_WAIT_REQ;
        else         state_nxt_s = ST_ERR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase

    oe_nxt_s   = 1'b0;
    cs_n_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_WR_SETUP, ST_WRITE: begin
        oe_nxt_s   = 1'b1;
        cs_n_nxt_s = 1'b0;
      end
      ST_TURN, ST_READ: begin
        oe_nxt_s   = 1'b0;
        cs_n_nxt_s = 1'b0;
      end
      default: begin
        oe_nxt_s   = 1'b0;
        cs_n_nxt_s = 1'b1;
      end
    endcase

    busy_nxt_s = (state_nxt_s != ST_IDLE);
    // Skip the capture on the exit cycle so rd_vld cannot overlap a driven bus
    rd_cap_s   = (state_r == ST_READ) && (state_nxt_s == ST_READ);
  end

  // State register plus turnaround and stall counters
  always_ff @(posedge I_clk_src_p) begin
    if (I_rst) begin
      state_r    <= ST_IDLE;
      turn_cnt_r <= 8'd0;
      tmo_cnt_r  <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r)
        turn_cnt_r <= 8'd0;
      else if ((state_r == ST_WR_SETUP) || (state_r == ST_TURN))
        turn_cnt_r <= turn_cnt_r + 8'd1;
      else
        turn_cnt_r <= 8'd0;
      if ((state_nxt_s != state_r) || !stall_s)
        tmo_cnt_r <= 16'd0;
      else
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end
  end

  // Registered pad-side controls, data path and sticky timeout flag
  always_ff @(posedge I_clk_src_p) begin
    if (I_rst) begin
      bus_oe_r   <= 1'b0;
      cs_n_r     <= 1'b1;
      busy_r     <= 1'b0;
      rd_vld_r   <= 1'b0;
      err_r      <= 1'b0;
      pad_data_r <= {DATA_W{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      bus_oe_r <= oe_nxt_s;
      cs_n_r   <= cs_n_nxt_s;
      busy_r   <= busy_nxt_s;
      rd_vld_r <= rd_cap_s;
      if (xfer_s) pad_data_r <= I_wr_data;
      else        pad_data_r <= pad_data_r;
      if (rd_cap_s) rd_data_r <= I_pad_data;
      else          rd_data_r <= rd_data_r;
      if (start_ok_s)                  err_r <= 1'b0;
      else if (state_nxt_s == ST_ERR)  err_r <= 1'b1;
      else                             err_r <= err_r;
    end
  end

  // Handshake and clock gate must act in the transfer cycle itself
  assign O_wr_rdy      = xfer_s;
  assign O_sck_en      = xfer_s || (state_r == ST_READ);
  assign O_pad_data    = pad_data_r;
  assign O_bus_oe      = bus_oe_r;
  assign O_OE_req      = bus_oe_r;
  assign O_rd_data     = rd_data_r;
  assign O_rd_vld      = rd_vld_r;
  assign O_spi_cs_n    = cs_n_r;
  assign O_busy        = busy_r;
  assign O_err_timeout = err_r;

endmodule

// File: tb/tb_asic_link_ctrl.sv
// Directed self-checking bench for asic_link_ctrl (TIMEOUT shortened to 100).
module tb_asic_link_ctrl;
  localparam int DW = 128;

  logic          clk;
  logic          rst;
  logic          start;
  logic          config_req;
  logic          switch_rdwr;
  logic          near_full;
  logic [DW-1:0] wr_data;
  logic          wr_vld;
  logic          wr_rdy;
  logic [DW-1:0] pad_data;
  logic          bus_oe;
  logic [DW-1:0] pad_in;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          oe_req;
  logic          cs_n;
  logic          sck_en;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  asic_link_ctrl #(
    .DATA_W(DW), .SYNC_STAGES(2), .TURN_CYC(4), .TIMEOUT(100)
  ) dut (
    .I_clk_src_p(clk), .I_rst(rst), .I_start(start),
    .I_config_req(config_req), .I_switch_rdwr(switch_rdwr), .I_near_full(near_full),
    .I_wr_data(wr_data), .I_wr_vld(wr_vld), .O_wr_rdy(wr_rdy),
    .O_pad_data(pad_data), .O_bus_oe(bus_oe), .I_pad_data(pad_in),
    .O_rd_data(rd_data), .O_rd_vld(rd_vld), .O_OE_req(oe_req),
    .O_spi_cs_n(cs_n), .O_sck_en(sck_en), .O_busy(busy), .O_err_timeout(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_oe", bus_oe, 1'b0);
    chk1("rst_oe_req", oe_req, 1'b0);
    chk1("rst_sck", sck_en, 1'b0);
    chk1("rst_rdy", wr_rdy, 1'b0);
    chk1("rst_rd_vld", rd_vld, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chkw("rst_pad_data", pad_data, {DW{1'b0}});
    chkw("rst_rd_data", rd_data, {DW{1'b0}});
  endtask

  // Called at a negedge with config_req already synchronized high, switch low
  task automatic open_session();
    wr_vld = 1'b1;
    wr_data = DW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("open_busy", busy, 1'b1);
    chk1("open_cs_n_wait", cs_n, 1'b1);
    @(negedge clk);
    chk1("setup_cs_n", cs_n, 1'b0);
    chk1("setup_oe", bus_oe, 1'b1);
    chk1("setup_oe_req", oe_req, 1'b1);
    chk1("setup_sck", sck_en, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1("setup_rdy", wr_rdy, 1'b0);
      chk1("setup_oe_hold", bus_oe, 1'b1);
    end
  endtask

  // Words 1..8; p gives the expected wr_rdy per cycle, near_full on cycles [nf_on, nf_off)
  task automatic burst(input logic [15:0] p, input int ncyc, input int nf_on, input int nf_off);
    int acc;
    acc = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chkw("burst_pad_data", pad_data, DW'(acc));
      chk1("burst_oe", bus_oe, 1'b1);
      chk1("burst_rd_vld", rd_vld, 1'b0);
      wr_vld = (acc < 8);
      wr_data = DW'(acc + 1);
      near_full = (i >= nf_on) && (i < nf_off);
      #1;
      chk1("burst_rdy", wr_rdy, p[i]);
      chk1("burst_sck", sck_en, p[i]);
      if (p[i]) acc++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    config_req = 1'b0;
    switch_rdwr = 1'b0;
    near_full = 1'b0;
    wr_data = {DW{1'b0}};
    wr_vld = 1'b0;
    pad_in = {16{8'hA5}};
    repeat (3) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    config_req = 1'b1;
    repeat (3) @(negedge clk);
    chk1("idle_busy", busy, 1'b0);

    // Clean write burst, then turnaround to read
    open_session();
    burst(16'h00FF, 9, 0, 0);
    switch_rdwr = 1'b1;
    @(negedge clk); chk1("turn_pre_oe1", bus_oe, 1'b1);
    @(negedge clk); chk1("turn_pre_oe2", bus_oe, 1'b1);
    @(negedge clk);
    chk1("turn_oe", bus_oe, 1'b0);
    chk1("turn_oe_req", oe_req, 1'b0);
    chk1("turn_cs_n", cs_n, 1'b0);
    chk1("turn_sck", sck_en, 1'b0);
    chk1("turn_busy", busy, 1'b1);
    chk1("turn_rd_vld", rd_vld, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1("turn_idle_oe", bus_oe, 1'b0);
      chk1("turn_idle_sck", sck_en, 1'b0);
      chk1("turn_idle_rd_vld", rd_vld, 1'b0);
    end
    @(negedge clk);
    chk1("read_first_sck", sck_en, 1'b1);
    chk1("read_first_rd_vld", rd_vld, 1'b0);
    @(negedge clk);
    chk1("read_vld_a5", rd_vld, 1'b1);
    chkw("read_data_a5", rd_data, {16{8'hA5}});
    chk1("read_oe", bus_oe, 1'b0);
    pad_in = {16{8'h5A}};
    @(negedge clk);
    chkw("read_data_5a", rd_data, {16{8'h5A}});
    chk1("read_vld_5a", rd_vld, 1'b1);
    config_req = 1'b0;
    switch_rdwr = 1'b0;
    @(negedge clk); chk1("read_sync_vld1", rd_vld, 1'b1);
    @(negedge clk); chk1("read_sync_vld2", rd_vld, 1'b1);
    @(negedge clk);
    chk1("done_cs_n", cs_n, 1'b1);
    chk1("done_busy", busy, 1'b1);
    chk1("done_rd_vld", rd_vld, 1'b0);
    chk1("done_sck", sck_en, 1'b0);
    chk1("done_oe", bus_oe, 1'b0);
    @(negedge clk);
    chk1("done_idle_busy", busy, 1'b0);
    chk1("done_idle_cs_n", cs_n, 1'b1);

    // Timeout: config_req held low
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("tmo_busy", busy, 1'b1);
    chk1("tmo_err_clear", err, 1'b0);
    repeat (99) @(negedge clk);
    chk1("tmo_before_err", err, 1'b0);
    chk1("tmo_before_busy", busy, 1'b1);
    @(negedge clk);
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_err_busy", busy, 1'b1);
    chk1("tmo_err_cs_n", cs_n, 1'b1);
    chk1("tmo_err_oe", bus_oe, 1'b0);
    repeat (5) @(negedge clk);
    chk1("tmo_err_sticky", err, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("tmo_restart_err", err, 1'b0);
    chk1("tmo_restart_busy", busy, 1'b1);
    config_req = 1'b1;
    wr_vld = 1'b1;
    wr_data = DW'(17);

    // Reset asserted while in WRITE
    repeat (3) @(negedge clk);
    chk1("rstw_setup_cs_n", cs_n, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk1("rstw_in_write", wr_rdy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    wr_vld = 1'b0;
    repeat (3) @(negedge clk);

    // Burst with near_full back-pressure, then DONE beats TURN
    open_session();
    burst(16'h1E0F, 14, 2, 7);
    config_req = 1'b0;
    switch_rdwr = 1'b1;
    @(negedge clk); chk1("both_pre_oe1", bus_oe, 1'b1);
    @(negedge clk);
    chk1("both_pre_oe2", bus_oe, 1'b1);
    chk1("both_pre_cs_n", cs_n, 1'b0);
    @(negedge clk);
    chk1("both_done_cs_n", cs_n, 1'b1);
    chk1("both_done_oe", bus_oe, 1'b0);
    chk1("both_done_busy", busy, 1'b1);
    @(negedge clk);
    chk1("both_idle_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
